ro_puf_ctrl: RTL



---
 rtl/ro_puf_pkg.sv | 8 +
 rtl/ro_edge_counter.sv | 22 ++
 rtl/ro_puf_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared FSM states and default timing constants for the RO-PUF sequencer
package ro_puf_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COUNT, S_DRAIN, S_COMPARE} state_t;
  localparam int CNT_W_DEF = 16;
  localparam int SETTLE_DEF = 8;
  localparam int WINDOW_DEF = 1024;
  localparam int DRAIN_LEN = 2;
endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: 2-FF synchronizer, rising-edge detect and saturating edge counter
module ro_edge_counter import ro_puf_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             count_en,
  input  logic             ro,
  output logic [CNT_W-1:0] cnt
);
  logic [2:0] sh;
  // two synchronizer stages plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh <= '0;
    else sh <= {sh[1:0], ro};
  // count synchronized rising edges, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (count_en && sh[1] && !sh[2] && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: RO-PUF challenge/response sequencer; RO_PUF_RAWCOUNT_EN adds cnt_a/cnt_b outputs
module ro_puf_ctrl import ro_puf_pkg::*; #(
  parameter int N_RO = 16,
  parameter int SEL_W = $clog2(N_RO),
  parameter int CNT_W = CNT_W_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] chal_a,
  input  logic [SEL_W-1:0] chal_b,
  output logic [N_RO-1:0]  ro_en,
  input  logic [N_RO-1:0]  ro_out,
  output logic             busy,
  output logic             done,
  output logic             resp,
  output logic             tie,
  output logic             err
`ifdef RO_PUF_RAWCOUNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);
  localparam int TMR_W = $clog2((WINDOW > SETTLE ? WINDOW : SETTLE) + 1);
  state_t state, state_d;
  logic [TMR_W-1:0] tmr, tmr_d;
  logic [SEL_W-1:0] a_q, b_q;
  logic [N_RO-1:0] en_d;
  logic [CNT_W-1:0] ca, cb;
  logic valid, accept, finish;
  assign valid = chal_a != chal_b && 32'(chal_a) < 32'(N_RO) && 32'(chal_b) < 32'(N_RO);
  assign accept = state == S_IDLE && start;
  assign finish = state == S_DRAIN && state_d == S_COMPARE;
  assign busy = state != S_IDLE;
  assign done = state == S_COMPARE;
  assign en_d = (state_d == S_SETTLE || state_d == S_COUNT) ?
                ((N_RO'(1) << (accept ? chal_a : a_q)) | (N_RO'(1) << (accept ? chal_b : b_q))) : '0;
  // phase sequencing; the timer restarts at every phase change
  always_comb begin
    state_d = state;
    tmr_d = tmr + 1'b1;
    case (state)
      S_IDLE: begin
        tmr_d = '0;
        if (start) state_d = valid ? S_SETTLE : S_COMPARE;
      end
      S_SETTLE: if (tmr == TMR_W'(SETTLE - 1)) begin
        state_d = S_COUNT;
        tmr_d = '0;
      end
      S_COUNT: if (tmr == TMR_W'(WINDOW - 1)) begin
        state_d = S_DRAIN;
        tmr_d = '0;
      end
      S_DRAIN: if (tmr == TMR_W'(DRAIN_LEN - 1)) begin
        state_d = S_COMPARE;
        tmr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state, timer, latched challenge and registered enables; reset stops the oscillators at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      tmr <= '0;
      a_q <= '0;
      b_q <= '0;
      ro_en <= '0;
    end else begin
      state <= state_d;
      tmr <= tmr_d;
      ro_en <= en_d;
      if (accept) begin
        a_q <= chal_a;
        b_q <= chal_b;
      end
    end
  // gating with the enable keeps an unselected arm's synchronizer fed with zeros
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst_n(rst_n), .clr(accept), .count_en(state == S_COUNT),
    .ro(ro_out[a_q] & ro_en[a_q]), .cnt(ca)
  );
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst_n(rst_n), .clr(accept), .count_en(state == S_COUNT),
    .ro(ro_out[b_q] & ro_en[b_q]), .cnt(cb)
  );
  // result flags clear on an accepted start and settle when the compare cycle begins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {resp, tie, err} <= '0;
    else if (accept) {resp, tie, err} <= {2'b00, !valid};
    else if (finish) {resp, tie, err} <= {ca > cb, ca == cb, 1'b0};
`ifdef RO_PUF_RAWCOUNT_EN
  // raw counts published alongside the result flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {cnt_a, cnt_b} <= '0;
    else if (accept) {cnt_a, cnt_b} <= '0;
    else if (finish) {cnt_a, cnt_b} <= {ca, cb};
`endif
endmodule
